// File: rtl/udc_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction and
// boundary-mode encodings plus the load clamping helper.
package udc_pkg;

    localparam logic UDC_UP   = 1'b1;
    localparam logic UDC_DOWN = 1'b0;

    // Widest counter the clamp helper can serve.
    localparam int UDC_CLAMP_W = 32;

    typedef enum logic {
        UDC_MODE_WRAP = 1'b0,
        UDC_MODE_SAT  = 1'b1
    } udc_mode_e;

    function automatic logic [UDC_CLAMP_W-1:0] udc_clamp(
        input logic [UDC_CLAMP_W-1:0] val,
        input logic [UDC_CLAMP_W-1:0] max
    );
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/udc_next_val.sv
// Combinational step logic: the count after one enabled edge in the given
// direction and mode, plus whether the current count sits on the boundary.
module udc_next_val
    import udc_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  udc_mode_e        mode,
    output logic [WIDTH-1:0] next_q,
    output logic             at_bound
);

    localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;

    // One spare bit so stepping past MAX_VAL or below 0 is visible before
    // truncation; a non-power-of-two MAX_VAL therefore returns to 0.
    assign inc = {1'b0, q} + ONE_EXT;
    assign dec = {1'b0, q} - ONE_EXT;

    always_comb begin
        next_q   = q;
        at_bound = 1'b0;
        if (dir == UDC_UP) begin
            at_bound = (q == MAX_VAL);
            if (inc > MAX_EXT) begin
                next_q = (mode == UDC_MODE_SAT) ? q : '0;
            end else begin
                next_q = inc[WIDTH-1:0];
            end
        end else begin
            at_bound = (dir == UDC_DOWN) && (q == '0);
            if (dec[WIDTH]) begin
                next_q = (mode == UDC_MODE_SAT) ? q : MAX_VAL;
            end else begin
                next_q = dec[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/up_down_counter_mod.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate boundary
// handling, terminal count and sticky overflow. Saturation built with UDC_SAT_EN.
module up_down_counter_mod
    import udc_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_up_down,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_sat,
    input  logic             i_flag_clr,
    output logic [WIDTH-1:0] o_Q,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_ovf
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] load_clamped;
    logic             at_bound;
    logic             boundary_evt;
    logic             wrap_r;
    logic             ovf_r;
    logic             ovf_d;
    udc_mode_e        mode;

`ifdef UDC_SAT_EN
    assign mode = i_sat ? UDC_MODE_SAT : UDC_MODE_WRAP;
`else
    // Port kept so both builds share one interface; the value is not used.
    logic unused_sat;
    assign unused_sat = i_sat;
    assign mode       = UDC_MODE_WRAP;
`endif

    udc_next_val #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_val (
        .q        (q_r),
        .dir      (i_up_down),
        .mode     (mode),
        .next_q   (step_q),
        .at_bound (at_bound)
    );

    assign load_clamped = WIDTH'(udc_clamp(UDC_CLAMP_W'(i_load_val), UDC_CLAMP_W'(MAX_VAL)));

    // Clear and load pre-empt counting, so they never raise a boundary event.
    assign boundary_evt = i_en && at_bound && !i_clr && !i_load;

    always_comb begin
        q_d = q_r;
        if (i_clr) begin
            q_d = '0;
        end else if (i_load) begin
            q_d = load_clamped;
        end else if (i_en) begin
            q_d = step_q;
        end
    end

    // A new event outranks a flag clear landing on the same edge.
    always_comb begin
        ovf_d = ovf_r;
        if (i_clr) begin
            ovf_d = 1'b0;
        end else if (boundary_evt) begin
            ovf_d = 1'b1;
        end else if (i_flag_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            q_r    <= q_d;
            wrap_r <= boundary_evt;
            ovf_r  <= ovf_d;
        end
    end

    assign o_Q    = q_r;
    assign o_tc   = at_bound;
    assign o_wrap = wrap_r;
    assign o_ovf  = ovf_r;

endmodule

// File: doc/up_down_counter_mod.md
# up_down_counter_mod

Parametrised successor to the 4-bit `up_down_counter`. It is a modulo-N up/down counter with:
- configurable width and terminal value,
- synchronous clear and parallel load,
- wrap or saturate behaviour at the boundaries,
- a terminal-count output and a sticky overflow flag.

It serves as the general-purpose event/timer counter for the datapath and replaces fixed-width instances.

## Interface
- `WIDTH`, 4, counter width in bits (≥2)
- `MAX_VAL`, 2**WIDTH-1, terminal value; the count range is 0..MAX_VAL (must be < 2**WIDTH)
- `i_clk`  in  1  single clock; all state updates on its rising edge
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_en`  in  1  count enable
- `i_up_down`  in  1  direction: 1 = up, 0 = down
- `i_clr`  in  1  synchronous clear to 0 (independent of `i_en`)
- `i_load`  in  1  synchronous parallel load (independent of `i_en`)
- `i_load_val`  in  WIDTH  load value
- `i_sat`  in  1  boundary mode: 1 = saturate, 0 = wrap (honoured only with `UDC_SAT_EN`)
- `i_flag_clr`  in  1  clears the sticky `o_ovf`
- `o_Q`  out  WIDTH  current count
- `o_tc`  out  1  terminal count: (up && `o_Q`==MAX_VAL) || (!up && `o_Q`==0); combinational from `o_Q`/`i_up_down`
- `o_wrap`  out  1  registered one-cycle pulse; a boundary event occurred on the previous edge
- `o_ovf`  out  1  sticky: a boundary event has occurred since the last reset or clear

## Operation
- Reset (`i_rst_n`=0, asynchronous): `o_Q`=0, `o_wrap`=0, `o_ovf`=0. Release is synchronous to the next edge.
- Per-edge priority: `i_clr` > `i_load` > count (`i_en`) > hold.
- Clear: `o_Q`←0. No boundary event.
- Load: `o_Q`←`i_load_val`. Values above MAX_VAL are clamped to MAX_VAL. No boundary event.
- Count up, not at MAX_VAL: `o_Q`+1. Count down, not at 0: `o_Q`−1.
- Boundary event = `i_en` && `o_tc` && no clear/load. Behaviour depends on the mode:
  - Wrap: up at MAX_VAL → 0; down at 0 → MAX_VAL.
  - Saturate: `o_Q` holds.
  - In both modes, the event sets `o_wrap` for exactly one cycle and sets `o_ovf`.
- Arithmetic is performed in WIDTH+1 bits. The result is never outside 0..MAX_VAL. Non-power-of-two MAX_VAL must wrap to 0, not to 2**WIDTH.
- `o_ovf` update on each edge:
  - a simultaneous boundary event and `i_flag_clr` → `o_ovf`=1 (set wins);
  - `i_flag_clr` alone → 0;
  - `i_clr` also clears `o_ovf`.
- A direction change takes effect on the same edge it is sampled. `o_tc` follows `i_up_down` combinationally.

## Timing
- Latency: one cycle from inputs sampled at edge N to `o_Q`, `o_wrap` and `o_ovf` valid after edge N.
- `o_tc` is combinational with no register. Downstream logic must register it if it is used off-block.
- `o_wrap` is high for one cycle per event. Consecutive events in saturate mode give consecutive pulses.
- Asserting reset mid-count forces all outputs to 0 immediately, independent of the clock.

## Configuration
- Macro: `UDC_SAT_EN`.
- Defined: `i_sat` selects saturate or wrap per cycle, and the saturate logic is built.
- Undefined: the counter always wraps. `i_sat` is ignored but the port remains, so the interface is unchanged.

## Structure
- Shared package `udc_pkg`:
  - localparams for the direction encoding (`UDC_UP`=1, `UDC_DOWN`=0);
  - the boundary-mode encoding;
  - a function `udc_clamp(val, max)` used for load clamping.
- One combinational sub-module, `udc_next_val`. Inputs: `o_Q`, direction, mode, MAX_VAL. Outputs: the next count and the boundary-event flag. The top level holds only registers and priority muxing.

## Test plan
All scenarios use WIDTH=4 and MAX_VAL=9 unless noted.
- Reset then count up: `i_rst_n` low 2 cycles, then release with `i_en`=1, up. Required: `o_Q` goes 0,1..9,0. `o_wrap` pulses on the cycle after the 9→0 transition. `o_ovf`=1 afterwards.
- Down wrap: load 2, count down. Required: `o_Q` goes 2,1,0,9,8. `o_tc`=1 while `o_Q`=0 and down.
- Saturate (`UDC_SAT_EN`, `i_sat`=1): count up from 8 for 4 cycles. Required: `o_Q` goes 8,9,9,9. `o_wrap` high on the last 2 cycles.
- Priority: on the same edge assert `i_clr`=1, `i_load`=1 with `i_load_val`=5, and `i_en`=1. Required: `o_Q`=0 and `o_ovf`=0. Then `i_load_val`=14 alone gives `o_Q`=9 (clamp).
- Async reset mid-count: drop `i_rst_n` between edges while `o_Q`=6. Required: `o_Q`=0 before the next edge. Set `i_flag_clr` concurrently with a wrap event: `o_ovf` stays 1.
- Full-range wrap: with WIDTH=4 and default MAX_VAL=15, count up across 15→0. `i_sat` is ignored when `UDC_SAT_EN` is undefined.
